// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback arbiter: result entry and pending counter.
package wb_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RW   = $clog2(NREG);

  typedef struct packed {
    logic [RW-1:0]   dest;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  typedef logic [1:0] pend_cnt_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding memory-unit results until they win the write port.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wb_entry_t              push_data,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A pop frees the slot being written, so a push into a full queue is fine then.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and memory results into one registered register-file write per cycle and
// tracks pending writes per register for decode RAW stalls.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIM = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  logic [RW-1:0]   iss_dest,
  output logic            iss_ready,
  input  logic [RW-1:0]   src_a,
  input  logic [RW-1:0]   src_b,
  output logic            a_pending,
  output logic            b_pending,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [RW-1:0]   alu_dest,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [RW-1:0]   mem_dest,
  input  logic [XLEN-1:0] mem_data,
  output logic            wb_load,
  output logic [RW-1:0]   wb_dest,
  output logic [XLEN-1:0] wb_data
);

  localparam int QW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [QW-1:0] Q_MAX = FIFO_DEPTH[QW-1:0];
  localparam logic [SW-1:0] S_MAX = STARVE_LIM[SW-1:0];

  wb_entry_t       q_head;
  wb_entry_t       mem_entry;
  wb_entry_t       win;
  logic            q_full;
  logic            q_empty;
  logic [QW-1:0]   q_count;
  logic            q_wins;
  logic            has_win;
  logic [SW-1:0]   starve;
  pend_cnt_t       cnt [NREG];
  logic [NREG-1:0] inc_vec;
  logic [NREG-1:0] dec_vec;

  assign mem_entry = '{dest: mem_dest, data: mem_data};
  assign mem_ready = (q_count < Q_MAX);

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (mem_valid && mem_ready),
    .push_data (mem_entry),
    .pop       (q_wins),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // Queue takes priority when it cannot accept more or has lost too often.
  assign q_wins    = !q_empty && (q_full || (starve == S_MAX) || !alu_valid);
  assign alu_ready = rst_n && alu_valid && !q_wins;
  assign has_win   = alu_ready || q_wins;
  assign win       = q_wins ? q_head : '{dest: alu_dest, data: alu_data};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_load <= 1'b0;
      wb_dest <= '0;
      wb_data <= '0;
      starve  <= '0;
    end else begin
      wb_load <= has_win && (win.dest != '0);
      if (has_win) begin
        wb_dest <= win.dest;
        wb_data <= win.data;
      end
      if (q_empty || q_wins)  starve <= '0;
      else if (starve != S_MAX) starve <= starve + 1'b1;
    end
  end

  assign iss_ready = rst_n && ((iss_dest == '0) || (cnt[iss_dest] != 2'd3) ||
                               (wb_load && (wb_dest == iss_dest)));

  // The write landing this cycle is forwarded by the register file, so it no longer pends.
  assign a_pending = (src_a != '0) &&
                     (cnt[src_a] > ((wb_load && (wb_dest == src_a)) ? 2'd1 : 2'd0));
  assign b_pending = (src_b != '0) &&
                     (cnt[src_b] > ((wb_load && (wb_dest == src_b)) ? 2'd1 : 2'd0));

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (iss_valid && iss_ready && (iss_dest != '0)) inc_vec[iss_dest] = 1'b1;
    if (wb_load) dec_vec[wb_dest] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          cnt[r] <= cnt[r] + 2'd1;
        else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != 2'd0))
          cnt[r] <= cnt[r] - 2'd1;
      end
    end
  end

  pend_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    wb_load |-> ((cnt[wb_dest] != 2'd0) || inc_vec[wb_dest]));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, ALU path, starvation, full queue, scoreboard, x0.
module tb_regfile_wb_arbiter;
  import wb_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            iss_valid;
  logic [RW-1:0]   iss_dest;
  logic            iss_ready;
  logic [RW-1:0]   src_a;
  logic [RW-1:0]   src_b;
  logic            a_pending;
  logic            b_pending;
  logic            alu_valid;
  logic            alu_ready;
  logic [RW-1:0]   alu_dest;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [RW-1:0]   mem_dest;
  logic [XLEN-1:0] mem_data;
  logic            wb_load;
  logic [RW-1:0]   wb_dest;
  logic [XLEN-1:0] wb_data;

  int n_cmp;
  int n_err;

  regfile_wb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_dest  (iss_dest),
    .iss_ready (iss_ready),
    .src_a     (src_a),
    .src_b     (src_b),
    .a_pending (a_pending),
    .b_pending (b_pending),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_dest  (alu_dest),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_dest  (mem_dest),
    .mem_data  (mem_data),
    .wb_load   (wb_load),
    .wb_dest   (wb_dest),
    .wb_data   (wb_data)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [RW-1:0] d);
    iss_valid = 1'b1;
    iss_dest  = d;
    tick();
    iss_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    alu_valid = 1'b1; alu_dest = 5'd4; alu_data = 32'hAAAA_0001;
    mem_valid = 1'b1; mem_dest = 5'd6; mem_data = 32'hBBBB_0002;
    iss_valid = 1'b1; iss_dest = 5'd3; src_a = 5'd3; src_b = 5'd6;
    tick();
    tick();
    n_cmp++; if (wb_load !== 1'b0) begin n_err++; $display("FAIL rst_wb_load: got %b want 0", wb_load); end
    n_cmp++; if (wb_dest !== 5'd0 || wb_data !== 32'd0) begin n_err++; $display("FAIL rst_wb_bus: got %0d/%h want 0/0", wb_dest, wb_data); end
    n_cmp++; if (a_pending !== 1'b0) begin n_err++; $display("FAIL rst_a_pending: got %b want 0", a_pending); end
    n_cmp++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL rst_mem_ready: got %b want 1", mem_ready); end
    n_cmp++; if (alu_ready !== 1'b0 || iss_ready !== 1'b0) begin n_err++; $display("FAIL rst_readys: got alu %b iss %b want 0 0", alu_ready, iss_ready); end
    alu_valid = 1'b0; mem_valid = 1'b0; iss_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    n_cmp++; if (wb_load !== 1'b0) begin n_err++; $display("FAIL post_rst_wb_load: got %b want 0", wb_load); end
  endtask

  task automatic test_alu_only();
    iss_valid = 1'b1; iss_dest = 5'd5;
    #1;
    n_cmp++; if (iss_ready !== 1'b1) begin n_err++; $display("FAIL alu_iss_ready: got %b want 1", iss_ready); end
    tick();
    iss_valid = 1'b0;
    src_a = 5'd5;
    #1;
    n_cmp++; if (a_pending !== 1'b1) begin n_err++; $display("FAIL alu_a_pending: got %b want 1", a_pending); end
    alu_valid = 1'b1; alu_dest = 5'd5; alu_data = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL alu_ready: got %b want 1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    n_cmp++; if (wb_load !== 1'b1 || wb_dest !== 5'd5 || wb_data !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL alu_wb: got %b/%0d/%h want 1/5/deadbeef", wb_load, wb_dest, wb_data); end
    tick();
    n_cmp++; if (wb_load !== 1'b0 || a_pending !== 1'b0) begin
      n_err++; $display("FAIL alu_after: got load %b pend %b want 0 0", wb_load, a_pending); end
  endtask

  task automatic test_starvation();
    issue(5'd7);
    alu_valid = 1'b1; alu_dest = 5'd0; alu_data = 32'h0000_0999;
    mem_valid = 1'b1; mem_dest = 5'd7; mem_data = 32'h0000_0011;
    #1;
    n_cmp++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin
      n_err++; $display("FAIL starve_push: got mem %b alu %b want 1 1", mem_ready, alu_ready); end
    tick();
    mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL starve_alu_win%0d: got %b want 1", i, alu_ready); end
      tick();
      n_cmp++; if (wb_load !== 1'b0) begin n_err++; $display("FAIL starve_x0_drop%0d: got %b want 0", i, wb_load); end
    end
    #1;
    n_cmp++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL starve_forced: got %b want 0", alu_ready); end
    tick();
    alu_valid = 1'b0;
    n_cmp++; if (wb_load !== 1'b1 || wb_dest !== 5'd7 || wb_data !== 32'h11) begin
      n_err++; $display("FAIL starve_wb: got %b/%0d/%h want 1/7/11", wb_load, wb_dest, wb_data); end
    tick();
  endtask

  task automatic test_full_queue();
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] exp;
    for (int i = 8; i < 12; i++) issue(RW'(i));
    alu_valid = 1'b1; alu_dest = 5'd0; alu_data = 32'h0;
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1; mem_dest = RW'(8 + i); mem_data = 32'h100 + i;
      exp_q.push_back(32'h100 + i);
      #1;
      n_cmp++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin
        n_err++; $display("FAIL full_push%0d: got mem %b alu %b want 1 1", i, mem_ready, alu_ready); end
      tick();
    end
    mem_valid = 1'b0;
    #1;
    n_cmp++; if (mem_ready !== 1'b0 || alu_ready !== 1'b0) begin
      n_err++; $display("FAIL full_state: got mem %b alu %b want 0 0", mem_ready, alu_ready); end
    tick();
    alu_valid = 1'b0;
    n_cmp++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL full_after_pop: got %b want 1", mem_ready); end
    for (int i = 0; i < 4; i++) begin
      exp = exp_q.pop_front();
      n_cmp++; if (wb_load !== 1'b1 || wb_dest !== RW'(8 + i) || wb_data !== exp) begin
        n_err++; $display("FAIL full_drain%0d: got %b/%0d/%h want 1/%0d/%h", i, wb_load, wb_dest, wb_data, 8 + i, exp); end
      tick();
    end
    n_cmp++; if (wb_load !== 1'b0) begin n_err++; $display("FAIL full_idle: got %b want 0", wb_load); end
  endtask

  task automatic test_scoreboard();
    src_a = 5'd3; src_b = 5'd3;
    for (int i = 0; i < 3; i++) begin
      iss_valid = 1'b1; iss_dest = 5'd3;
      #1;
      n_cmp++; if (iss_ready !== 1'b1) begin n_err++; $display("FAIL sb_issue%0d: got %b want 1", i, iss_ready); end
      tick();
    end
    #1;
    n_cmp++; if (iss_ready !== 1'b0) begin n_err++; $display("FAIL sb_saturated: got %b want 0", iss_ready); end
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'h33;
    tick();
    alu_valid = 1'b0;
    #1;
    n_cmp++; if (iss_ready !== 1'b1) begin n_err++; $display("FAIL sb_bypass_ready: got %b want 1", iss_ready); end
    tick();
    n_cmp++; if (a_pending !== 1'b1 || b_pending !== 1'b1 || iss_ready !== 1'b1) begin
      n_err++; $display("FAIL sb_count2: got a %b b %b rdy %b want 1 1 1", a_pending, b_pending, iss_ready); end
    alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'h44;
    tick();
    alu_valid = 1'b0;
    issue(5'd3);
    #1;
    n_cmp++; if (iss_ready !== 1'b1) begin n_err++; $display("FAIL sb_same_cycle: got %b want 1", iss_ready); end
    issue(5'd3);
    #1;
    n_cmp++; if (iss_ready !== 1'b0) begin n_err++; $display("FAIL sb_resaturated: got %b want 0", iss_ready); end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] d;
    alu_dest = 5'd3;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; d = 32'hC0DE_0000 + i; alu_data = d;
      #1;
      n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready%0d: got %b want 1", i, alu_ready); end
      tick();
      n_cmp++; if (wb_load !== 1'b1 || wb_dest !== 5'd3 || wb_data !== d) begin
        n_err++; $display("FAIL b2b_wb%0d: got %b/%0d/%h want 1/3/%h", i, wb_load, wb_dest, wb_data, d); end
    end
    alu_valid = 1'b0;
    tick();
    n_cmp++; if (a_pending !== 1'b0 || b_pending !== 1'b0) begin
      n_err++; $display("FAIL b2b_cleared: got a %b b %b want 0 0", a_pending, b_pending); end
  endtask

  task automatic test_x0();
    alu_valid = 1'b1; alu_dest = 5'd0; alu_data = 32'h55;
    #1;
    n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL x0_alu_ready: got %b want 1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    n_cmp++; if (wb_load !== 1'b0) begin n_err++; $display("FAIL x0_wb_load: got %b want 0", wb_load); end
    src_a = 5'd0; src_b = 5'd0;
    for (int i = 0; i < 4; i++) begin
      iss_valid = 1'b1; iss_dest = 5'd0;
      #1;
      n_cmp++; if (iss_ready !== 1'b1) begin n_err++; $display("FAIL x0_iss%0d: got %b want 1", i, iss_ready); end
      tick();
    end
    iss_valid = 1'b0;
    #1;
    n_cmp++; if (a_pending !== 1'b0 || b_pending !== 1'b0) begin
      n_err++; $display("FAIL x0_pending: got a %b b %b want 0 0", a_pending, b_pending); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; iss_valid = 1'b0; iss_dest = '0; src_a = '0; src_b = '0;
    alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
    mem_valid = 1'b0; mem_dest = '0; mem_data = '0;
    test_reset();
    test_alu_only();
    test_starvation();
    test_full_queue();
    test_scoreboard();
    test_back_to_back();
    test_x0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
